// File: rtl/dmi_tck_sync_bridge.sv
// Carries one-pulse DMI commands from the JTAG tck domain to a core-clk valid/ready DMI port via a
// toggle req/ack handshake, and returns data and RISC-V busy/error sticky status. Optional DMI_TIMEOUT_EN.
`timescale 1ns/1ps
module dmi_tck_sync_bridge #(
  parameter int ABITS          = 7,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             trst,
  input  logic             tck,
  input  logic             clk,
  input  logic             wr_intf,
  input  logic             wr_enab,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             dmi_reset,
  input  logic             dmi_hard_reset,
  output logic [31:0]      rd_data,
  output logic [1:0]       rd_status,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_wdata,
  output logic             dmi_req_write,
  input  logic             dmi_rsp_valid,
  input  logic [31:0]      dmi_rsp_data,
  input  logic             dmi_rsp_err
);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_REQ  = 2'd1,
    C_RSP  = 2'd2
  } core_state_e;

  // tck domain
  logic                   req_tgl_q, req_tgl_d;
  logic                   pend_q, pend_d;
  logic                   discard_q, discard_d;
  logic [1:0]             sticky_q, sticky_d;
  logic [31:0]            rd_data_q, rd_data_d;
  logic [ABITS-1:0]       cmd_addr_q, cmd_addr_d;
  logic [31:0]            cmd_data_q, cmd_data_d;
  logic                   cmd_write_q, cmd_write_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   ack_seen_q, ack_seen_d;
  logic                   ack_event;

  // clk domain
  logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
  logic                   clk_rst_n;
  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
  logic                   req_seen_q, req_seen_d;
  logic                   ack_tgl_q, ack_tgl_d;
  core_state_e            state_q, state_d;
  logic                   valid_q, valid_d;
  logic [ABITS-1:0]       req_addr_q, req_addr_d;
  logic [31:0]            req_wdata_q, req_wdata_d;
  logic                   req_write_q, req_write_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;

  logic unused_bits;
`ifdef DMI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign unused_bits = ^wr_addr[31:ABITS];
`else
  assign unused_bits = ^{wr_addr[31:ABITS], TIMEOUT_CYCLES[0]};
`endif

  // Order of precedence on one tck edge: status resets, then the returning ack, then a new command.
  always_comb begin
    ack_sync_d  = {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_q};
    ack_seen_d  = ack_sync_q[SYNC_STAGES-1];
    ack_event   = ack_sync_q[SYNC_STAGES-1] ^ ack_seen_q;
    req_tgl_d   = req_tgl_q;
    pend_d      = pend_q;
    discard_d   = discard_q;
    sticky_d    = sticky_q;
    rd_data_d   = rd_data_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_write_d = cmd_write_q;

    if (dmi_reset || dmi_hard_reset) sticky_d = 2'b00;
    if (dmi_hard_reset && pend_q) discard_d = 1'b1;

    if (ack_event) begin
      pend_d = 1'b0;
      if (discard_d) begin
        discard_d = 1'b0;
      end else begin
        rd_data_d = rsp_data_q;
        if (rsp_err_q && sticky_d != 2'b11) sticky_d = 2'b10;
      end
    end

    if (wr_intf) begin
      if (!pend_d) begin
        cmd_addr_d  = wr_addr[ABITS-1:0];
        cmd_data_d  = wr_data;
        cmd_write_d = wr_enab;
        req_tgl_d   = ~req_tgl_q;
        pend_d      = 1'b1;
      end else begin
        sticky_d = 2'b11;
      end
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      req_tgl_q   <= 1'b0;
      pend_q      <= 1'b0;
      discard_q   <= 1'b0;
      sticky_q    <= 2'b00;
      rd_data_q   <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_write_q <= 1'b0;
      ack_sync_q  <= '0;
      ack_seen_q  <= 1'b0;
    end else begin
      req_tgl_q   <= req_tgl_d;
      pend_q      <= pend_d;
      discard_q   <= discard_d;
      sticky_q    <= sticky_d;
      rd_data_q   <= rd_data_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_write_q <= cmd_write_d;
      ack_sync_q  <= ack_sync_d;
      ack_seen_q  <= ack_seen_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_status = (pend_q || sticky_q == 2'b11) ? 2'b11 :
                     (sticky_q == 2'b10)           ? 2'b10 : 2'b00;

  // Core reset asserts with trst immediately and releases after SYNC_STAGES clk edges.
  assign rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  assign clk_rst_n  = rst_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge trst) begin
    if (!trst) rst_sync_q <= '0;
    else       rst_sync_q <= rst_sync_d;
  end

  always_comb begin
    req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
    req_seen_d  = req_seen_q;
    ack_tgl_d   = ack_tgl_q;
    state_d     = state_q;
    valid_d     = valid_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_write_d = req_write_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef DMI_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      C_IDLE: begin
        // Command holding registers are stable while the tck side is pending, so sampling them here is safe.
        if (req_sync_q[SYNC_STAGES-1] != req_seen_q) begin
          req_seen_d  = req_sync_q[SYNC_STAGES-1];
          req_addr_d  = cmd_addr_q;
          req_wdata_d = cmd_data_q;
          req_write_d = cmd_write_q;
          valid_d     = 1'b1;
          state_d     = C_REQ;
`ifdef DMI_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      C_REQ: begin
        if (dmi_req_ready) begin
          valid_d = 1'b0;
          state_d = C_RSP;
        end
      end
      C_RSP: begin
        if (dmi_rsp_valid) begin
          rsp_data_d = dmi_rsp_data;
          rsp_err_d  = dmi_rsp_err;
          ack_tgl_d  = ~ack_tgl_q;
          state_d    = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase

`ifdef DMI_TIMEOUT_EN
    if (state_q == C_REQ || state_q == C_RSP) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        valid_d    = 1'b0;
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
        ack_tgl_d  = ~ack_tgl_q;
        state_d    = C_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge clk_rst_n) begin
    if (!clk_rst_n) begin
      req_sync_q  <= '0;
      req_seen_q  <= 1'b0;
      ack_tgl_q   <= 1'b0;
      state_q     <= C_IDLE;
      valid_q     <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_write_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef DMI_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      req_sync_q  <= req_sync_d;
      req_seen_q  <= req_seen_d;
      ack_tgl_q   <= ack_tgl_d;
      state_q     <= state_d;
      valid_q     <= valid_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_write_q <= req_write_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef DMI_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign dmi_req_valid = valid_q;
  assign dmi_req_addr  = req_addr_q;
  assign dmi_req_wdata = req_wdata_q;
  assign dmi_req_write = req_write_q;

endmodule
